// File: rtl/vga_dtg_1024x768_if.sv
// Video timing bundle from the display timing generator to its pixel-domain consumers.
// Outputs are registered in the generator; there is no backpressure.
interface vga_dtg_1024x768_if;
  logic [11:0] pixel_column;
  logic [11:0] pixel_row;
  logic        video_on;
  logic        horiz_sync;
  logic        vert_sync;
  logic        frame_tick;
  logic [15:0] frame_count;

  modport master (
    output pixel_column, pixel_row, video_on, horiz_sync, vert_sync, frame_tick, frame_count
  );
  modport slave (
    input  pixel_column, pixel_row, video_on, horiz_sync, vert_sync, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_dtg_1024x768.sv
// Free-running VGA display timing generator; one register stage from counters to outputs, free-running.
// DTG_SYNC_DELAY_EN adds SYNC_DELAY stages on video_on/horiz_sync/vert_sync only.
module vga_dtg_1024x768 #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 144,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 2
) (
  input  logic                  clk_75,
  input  logic                  rstn,
  vga_dtg_1024x768_if.master    vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        SYNC_OFF = ~SYNC_POL;

`ifdef DTG_SYNC_DELAY_EN
  localparam int DLY_STAGES = SYNC_DELAY;
`else
  localparam int DLY_STAGES = 0 * SYNC_DELAY;
`endif

  logic [11:0] h_nxt_q, h_nxt_d;
  logic [11:0] v_nxt_q, v_nxt_d;
  logic [11:0] col_q, col_d;
  logic [11:0] row_q, row_d;
  logic        video_on_q, video_on_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        tick_q, tick_d;
  logic [15:0] fcount_q, fcount_d;

  // Outputs decode the position the counters hold now, so they lag the counters by one edge.
  always_comb begin
    h_nxt_d    = (h_nxt_q == H_LAST) ? 12'd0 : h_nxt_q + 12'd1;
    v_nxt_d    = v_nxt_q;
    if (h_nxt_q == H_LAST) begin
      v_nxt_d = (v_nxt_q == V_LAST) ? 12'd0 : v_nxt_q + 12'd1;
    end
    col_d      = h_nxt_q;
    row_d      = v_nxt_q;
    video_on_d = (h_nxt_q < H_ACT) && (v_nxt_q < V_ACT);
    hsync_d    = ((h_nxt_q >= HS_BEG) && (h_nxt_q <= HS_END)) ? SYNC_POL : SYNC_OFF;
    vsync_d    = ((v_nxt_q >= VS_BEG) && (v_nxt_q <= VS_END)) ? SYNC_POL : SYNC_OFF;
    tick_d     = (v_nxt_q == V_ACT) && (h_nxt_q == 12'd0);
    fcount_d   = tick_d ? fcount_q + 16'd1 : fcount_q;
  end

  always_ff @(posedge clk_75 or negedge rstn) begin
    if (!rstn) begin
      h_nxt_q    <= 12'd0;
      v_nxt_q    <= 12'd0;
      col_q      <= 12'd0;
      row_q      <= 12'd0;
      video_on_q <= 1'b0;
      hsync_q    <= SYNC_OFF;
      vsync_q    <= SYNC_OFF;
      tick_q     <= 1'b0;
      fcount_q   <= 16'd0;
    end else begin
      h_nxt_q    <= h_nxt_d;
      v_nxt_q    <= v_nxt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      tick_q     <= tick_d;
      fcount_q   <= fcount_d;
    end
  end

  assign vga.pixel_column = col_q;
  assign vga.pixel_row    = row_q;
  assign vga.frame_tick   = tick_q;
  assign vga.frame_count  = fcount_q;

  generate
    if (DLY_STAGES > 0) begin : g_dly
      logic [DLY_STAGES-1:0] vid_dly_q, vid_dly_d;
      logic [DLY_STAGES-1:0] hs_dly_q, hs_dly_d;
      logic [DLY_STAGES-1:0] vs_dly_q, vs_dly_d;

      always_comb begin
        vid_dly_d    = vid_dly_q;
        hs_dly_d     = hs_dly_q;
        vs_dly_d     = vs_dly_q;
        vid_dly_d[0] = video_on_q;
        hs_dly_d[0]  = hsync_q;
        vs_dly_d[0]  = vsync_q;
        for (int i = 1; i < DLY_STAGES; i++) begin
          vid_dly_d[i] = vid_dly_q[i-1];
          hs_dly_d[i]  = hs_dly_q[i-1];
          vs_dly_d[i]  = vs_dly_q[i-1];
        end
      end

      always_ff @(posedge clk_75 or negedge rstn) begin
        if (!rstn) begin
          vid_dly_q <= '0;
          hs_dly_q  <= {DLY_STAGES{SYNC_OFF}};
          vs_dly_q  <= {DLY_STAGES{SYNC_OFF}};
        end else begin
          vid_dly_q <= vid_dly_d;
          hs_dly_q  <= hs_dly_d;
          vs_dly_q  <= vs_dly_d;
        end
      end

      assign vga.video_on   = vid_dly_q[DLY_STAGES-1];
      assign vga.horiz_sync = hs_dly_q[DLY_STAGES-1];
      assign vga.vert_sync  = vs_dly_q[DLY_STAGES-1];
    end else begin : g_nodly
      assign vga.video_on   = video_on_q;
      assign vga.horiz_sync = hsync_q;
      assign vga.vert_sync  = vsync_q;
    end
  endgenerate

endmodule

// File: tb/tb_vga_dtg_1024x768.sv
// Directed bench: default-timing instance for reset/line decode, a small-raster instance
// (active-high syncs) for frame decode, frame counter, wrap and mid-frame reset.
module tb_vga_dtg_1024x768;

`ifdef DTG_SYNC_DELAY_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  // Small raster: H 16+2+4+2 = 24, V 10+1+2+3 = 16, frame = 384 clocks, sync cols 18..21, rows 11..12.
  localparam int SH_TOT = 24;
  localparam int SV_TOT = 16;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  logic clk_75 = 1'b0;
  logic rstn   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_75 = ~clk_75;

  vga_dtg_1024x768_if if_d ();
  vga_dtg_1024x768_if if_s ();

  vga_dtg_1024x768 dut_d (
    .clk_75 (clk_75),
    .rstn   (rstn),
    .vga    (if_d.master)
  );

  vga_dtg_1024x768 #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1), .SYNC_DELAY (2)
  ) dut_s (
    .clk_75 (clk_75),
    .rstn   (rstn),
    .vga    (if_s.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_75);
    @(negedge clk_75);
  endtask

  initial begin
    int lc, lr, lag, n;
    logic ev, eh, evs;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk_75);
    chk("rst_d_col",   if_d.pixel_column, 0);
    chk("rst_d_row",   if_d.pixel_row, 0);
    chk("rst_d_video", if_d.video_on, 0);
    chk("rst_d_hs",    if_d.horiz_sync, 1);
    chk("rst_d_vs",    if_d.vert_sync, 1);
    chk("rst_d_tick",  if_d.frame_tick, 0);
    chk("rst_d_fc",    if_d.frame_count, 0);
    chk("rst_s_hs",    if_s.horiz_sync, 0);
    chk("rst_s_vs",    if_s.vert_sync, 0);

    rstn = 1'b1;
    step(1);
    chk("first_d_col",   if_d.pixel_column, 0);
    chk("first_d_row",   if_d.pixel_row, 0);
    chk("first_d_video", if_d.video_on, (DLY == 0) ? 1 : 0);
    chk("first_s_video", if_s.video_on, (DLY == 0) ? 1 : 0);

    // One full default line on row 0
    for (int c = 0; c < 1328; c++) begin
      lc = c - DLY;
      ev = (lc >= 0) && (lc < 1024);
      eh = !((lc >= 1048) && (lc <= 1183));
      chk($sformatf("line_col%0d", c),   if_d.pixel_column, c);
      chk($sformatf("line_row%0d", c),   if_d.pixel_row, 0);
      chk($sformatf("line_video%0d", c), if_d.video_on, ev);
      chk($sformatf("line_hs%0d", c),    if_d.horiz_sync, eh);
      chk($sformatf("line_vs%0d", c),    if_d.vert_sync, 1);
      chk($sformatf("line_tick%0d", c),  if_d.frame_tick, 0);
      step(1);
    end
    chk("hwrap_col", if_d.pixel_column, 0);
    chk("hwrap_row", if_d.pixel_row, 1);

    // Restart both instances together for the frame tests
    rstn = 1'b0;
    repeat (2) @(negedge clk_75);
    rstn = 1'b1;
    step(1);

    for (int r = 0; r < SV_TOT; r++) begin
      for (int c = 0; c < SH_TOT; c++) begin
        lag = r * SH_TOT + c - DLY;
        if (lag < 0) lag = lag + S_FRAME;
        lr  = lag / SH_TOT;
        lc  = lag % SH_TOT;
        ev  = (lc < 16) && (lr < 10);
        eh  = (lc >= 18) && (lc <= 21);
        evs = (lr >= 11) && (lr <= 12);
        chk($sformatf("frm_col_r%0d_c%0d", r, c),   if_s.pixel_column, c);
        chk($sformatf("frm_row_r%0d_c%0d", r, c),   if_s.pixel_row, r);
        chk($sformatf("frm_video_r%0d_c%0d", r, c), if_s.video_on, ev);
        chk($sformatf("frm_hs_r%0d_c%0d", r, c),    if_s.horiz_sync, eh);
        chk($sformatf("frm_vs_r%0d_c%0d", r, c),    if_s.vert_sync, evs);
        chk($sformatf("frm_tick_r%0d_c%0d", r, c),  if_s.frame_tick, (r == 10 && c == 0) ? 1 : 0);
        chk($sformatf("frm_fc_r%0d_c%0d", r, c),    if_s.frame_count, (r >= 10) ? 1 : 0);
        step(1);
      end
    end
    chk("vwrap_col", if_s.pixel_column, 0);
    chk("vwrap_row", if_s.pixel_row, 0);
    chk("vwrap_fc",  if_s.frame_count, 1);

    step(2 * S_FRAME);
    chk("fc3_col", if_s.pixel_column, 0);
    chk("fc3_row", if_s.pixel_row, 0);
    chk("fc3",     if_s.frame_count, 3);

    // Tick spacing
    n = 0;
    while (!if_s.frame_tick && n < 2 * S_FRAME) begin
      step(1);
      n++;
    end
    chk("tick_seen", if_s.frame_tick, 1);
    step(1);
    n = 1;
    while (!if_s.frame_tick && n < 2 * S_FRAME) begin
      step(1);
      n++;
    end
    chk("tick_spacing", n, S_FRAME);
    chk("tick_fc5",     if_s.frame_count, 5);

    // Frame counter wrap
    step(1);
    force dut_s.fcount_q = 16'hFFFF;
    step(1);
    release dut_s.fcount_q;
    chk("fc_forced", if_s.frame_count, 16'hFFFF);
    n = 0;
    while (!if_s.frame_tick && n < 2 * S_FRAME) begin
      step(1);
      n++;
    end
    chk("wrap_tick", if_s.frame_tick, 1);
    chk("wrap_row",  if_s.pixel_row, 10);
    chk("wrap_col",  if_s.pixel_column, 0);
    chk("wrap_fc",   if_s.frame_count, 0);

    // Mid-frame asynchronous reset inside the vertical sync rows
    step(2 * SH_TOT + 5);
    chk("pre_rst_row", if_s.pixel_row, 12);
    chk("pre_rst_col", if_s.pixel_column, 5);
    chk("pre_rst_vs",  if_s.vert_sync, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_col",   if_s.pixel_column, 0);
    chk("async_row",   if_s.pixel_row, 0);
    chk("async_video", if_s.video_on, 0);
    chk("async_hs",    if_s.horiz_sync, 0);
    chk("async_vs",    if_s.vert_sync, 0);
    chk("async_tick",  if_s.frame_tick, 0);
    chk("async_fc",    if_s.frame_count, 0);
    chk("async_d_hs",  if_d.horiz_sync, 1);
    repeat (3) @(negedge clk_75);
    rstn = 1'b1;
    step(1);
    chk("rel_col",   if_s.pixel_column, 0);
    chk("rel_row",   if_s.pixel_row, 0);
    chk("rel_video", if_s.video_on, (DLY == 0) ? 1 : 0);
    chk("rel_fc",    if_s.frame_count, 0);
    chk("rel_vs",    if_s.vert_sync, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
